// File: rtl/cpu_pkg.sv
// Shared ALU definitions: datapath width, operation codes and flag bit positions.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package cpu_pkg;

    localparam int ALU_WIDTH = 4;

    // Operation select as driven by the sequencer
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } alu_op_t;

    // Bit positions inside the packed flag register
    localparam int FLAG_C    = 0;
    localparam int FLAG_Z    = 1;
    localparam int FLAG_V    = 2;
    localparam int NUM_FLAGS = 3;

    typedef logic [NUM_FLAGS-1:0] flags_t;

endpackage : cpu_pkg

// File: rtl/alu_core_comb.sv
// Combinational ALU: add, subtract (a-b), AND, OR with carry and signed-overflow outputs.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; outputs follow the inputs continuously.
module alu_core_comb
    import cpu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] r,
    output logic             c,
    output logic             ov
);

    localparam int MSB = WIDTH - 1;

    // One extra bit holds the carry-out; subtract is a + ~b + 1 so carry means no borrow
    logic [WIDTH:0] sum;

    // Select the operation and derive signed overflow from the operand/result sign bits
    always_comb begin
        sum = '0;
        ov  = 1'b0;
        case (alu_op_t'(op))
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                ov  = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                sum = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
                ov  = (a[MSB] != b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_AND: sum = {1'b0, a & b};
            OP_OR:  sum = {1'b0, a | b};
            default: begin
                sum = '0;
                ov  = 1'b0;
            end
        endcase
    end

    assign r = sum[WIDTH-1:0];
    assign c = sum[WIDTH];

endmodule : alu_core_comb

// File: rtl/alu_flags_4bit.sv
// ALU stage: registers the ALU result and C/Z/V flags on a latching edge and gates the result onto the bus.
// Latency: 1 main_clock from operands to result_q/bus; bus follows out_en combinationally.
// Backpressure: none; alu_latch/flags_en qualify updates, otherwise state holds.
module alu_flags_4bit
    import cpu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             main_clock,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             alu_latch,
    input  logic             flags_en,
    input  logic             out_en,
    output logic [WIDTH-1:0] bus,
    output logic [WIDTH-1:0] result_q,
    output logic             carry_flag,
    output logic             zero_flag,
    output logic             overflow_flag,
    output logic             busy_led
);

    logic [WIDTH-1:0] alu_r;
    logic             alu_c;
    logic             alu_ov;

    logic [WIDTH-1:0] result_d;
    flags_t           flags_d;
    flags_t           flags_q;
    logic             busy_d;
    logic             busy_q;

    alu_core_comb #(
        .WIDTH (WIDTH)
    ) u_core (
        .a  (a),
        .b  (b),
        .op (op),
        .r  (alu_r),
        .c  (alu_c),
        .ov (alu_ov)
    );

    // Next-state: result moves on a latch, flags only when also enabled; busy mirrors the latch strobe
    always_comb begin
        result_d = result_q;
        flags_d  = flags_q;
        busy_d   = alu_latch;
        if (alu_latch) begin
            result_d = alu_r;
            if (flags_en) begin
                flags_d[FLAG_C] = alu_c;
                flags_d[FLAG_Z] = (alu_r == '0);
                flags_d[FLAG_V] = alu_ov;
            end
        end
    end

    // Result, flag and busy registers; asynchronous reset clears everything at once
    always_ff @(posedge main_clock or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            flags_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
            busy_q   <= busy_d;
        end
    end

    // The bus carries the registered value only, so a same-cycle bus loop cannot form in here
    assign bus           = out_en ? result_q : '0;
    assign carry_flag    = flags_q[FLAG_C];
    assign zero_flag     = flags_q[FLAG_Z];
    assign overflow_flag = flags_q[FLAG_V];
    assign busy_led      = busy_q;

endmodule : alu_flags_4bit

// File: tb/tb_alu_flags_4bit.sv
module tb_alu_flags_4bit;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic       alu_latch;
    logic       flags_en;
    logic       out_en;
    logic [3:0] bus;
    logic [3:0] result_q;
    logic       carry_flag;
    logic       zero_flag;
    logic       overflow_flag;
    logic       busy_led;

    int tests;
    int fails;
    bit check_en;

    // model state
    int m_result;
    int m_c;
    int m_z;
    int m_v;
    int m_busy;

    alu_flags_4bit #(.WIDTH(4)) dut (
        .main_clock    (clk),
        .rst_n         (rst_n),
        .a             (a),
        .b             (b),
        .op            (op),
        .alu_latch     (alu_latch),
        .flags_en      (flags_en),
        .out_en        (out_en),
        .bus           (bus),
        .result_q      (result_q),
        .carry_flag    (carry_flag),
        .zero_flag     (zero_flag),
        .overflow_flag (overflow_flag),
        .busy_led      (busy_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Integer arithmetic on unsigned and two's-complement interpretations
    function automatic void model_op(input int ua, input int ub, input int opc,
                                     output int r, output int c, output int z, output int v);
        int sa;
        int sb;
        int full;
        int sfull;
        bit arith;
        sa    = (ua >= 8) ? ua - 16 : ua;
        sb    = (ub >= 8) ? ub - 16 : ub;
        arith = 1'b0;
        full  = 0;
        sfull = 0;
        c     = 0;
        case (opc)
            0: begin full = ua + ub; sfull = sa + sb; c = (full >= 16) ? 1 : 0; arith = 1'b1; end
            1: begin full = ua - ub; sfull = sa - sb; c = (ua >= ub) ? 1 : 0;   arith = 1'b1; end
            2: full = ua & ub;
            default: full = ua | ub;
        endcase
        r = ((full % 16) + 16) % 16;
        z = (r == 0) ? 1 : 0;
        v = (arith && (sfull > 7 || sfull < -8)) ? 1 : 0;
    endfunction

    // Reference model of the registered state
    always @(posedge clk or negedge rst_n) begin
        int r, c, z, v;
        if (!rst_n) begin
            m_result = 0; m_c = 0; m_z = 0; m_v = 0; m_busy = 0;
        end else begin
            m_busy = alu_latch ? 1 : 0;
            if (alu_latch) begin
                model_op(int'(a), int'(b), int'(op), r, c, z, v);
                m_result = r;
                if (flags_en) begin
                    m_c = c; m_z = z; m_v = v;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (check_en) begin
            chk("cmp_result", int'(result_q), m_result);
            chk("cmp_carry", int'(carry_flag), m_c);
            chk("cmp_zero", int'(zero_flag), m_z);
            chk("cmp_ovf", int'(overflow_flag), m_v);
            chk("cmp_busy", int'(busy_led), m_busy);
            chk("cmp_bus", int'(bus), out_en ? m_result : 0);
        end
    end

    // Drive one set of inputs just after an edge, then step past the next edge
    task automatic cyc(input logic [3:0] ia, input logic [3:0] ib, input logic [1:0] iop,
                       input logic il, input logic ife, input logic ioe);
        a = ia; b = ib; op = iop; alu_latch = il; flags_en = ife; out_en = ioe;
        @(posedge clk); #1;
    endtask

    task automatic chk_state(input string name, input int r, input int c, input int z, input int v);
        chk({name, "_r"}, int'(result_q), r);
        chk({name, "_c"}, int'(carry_flag), c);
        chk({name, "_z"}, int'(zero_flag), z);
        chk({name, "_v"}, int'(overflow_flag), v);
    endtask

    initial begin
        int mr, mc, mz, mv;
        tests = 0; fails = 0; check_en = 1'b0;
        rst_n = 1'b0;
        a = 4'd0; b = 4'd0; op = 2'b00; alu_latch = 1'b0; flags_en = 1'b0; out_en = 1'b1;

        // model self-pins against hand-computed values
        model_op(9, 8, 0, mr, mc, mz, mv);
        chk("pin_add98", mr * 1000 + mc * 100 + mz * 10 + mv, 1101);
        model_op(0, 1, 1, mr, mc, mz, mv);
        chk("pin_sub01", mr * 1000 + mc * 100 + mz * 10 + mv, 15000);
        model_op(8, 1, 1, mr, mc, mz, mv);
        chk("pin_sub81", mr * 1000 + mc * 100 + mz * 10 + mv, 7101);

        #1;
        chk_state("reset", 0, 0, 0, 0);
        chk("reset_bus", int'(bus), 0);
        chk("reset_busy", int'(busy_led), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_en = 1'b1;

        // reset mid-operation, between edges
        cyc(4'd5, 4'd3, 2'b00, 1'b1, 1'b1, 1'b1);
        chk_state("add53", 8, 0, 0, 1);
        chk("add53_bus", int'(bus), 8);
        #1 rst_n = 1'b0;
        #1;
        chk_state("midrst", 0, 0, 0, 0);
        chk("midrst_bus", int'(bus), 0);
        chk("midrst_busy", int'(busy_led), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // add with carry and overflow, bus gating
        cyc(4'd9, 4'd8, 2'b00, 1'b1, 1'b1, 1'b1);
        chk_state("add98", 1, 1, 0, 1);
        chk("add98_bus", int'(bus), 1);
        chk("add98_busy", int'(busy_led), 1);
        cyc(4'd9, 4'd8, 2'b00, 1'b1, 1'b1, 1'b0);
        chk("add98_bus_off", int'(bus), 0);

        // subtract: bus shows the old value until the edge
        a = 4'd3; b = 4'd5; op = 2'b01; alu_latch = 1'b1; flags_en = 1'b1; out_en = 1'b1;
        #1 chk("sub35_bus_old", int'(bus), 1);
        @(posedge clk); #1;
        chk_state("sub35", 14, 0, 0, 0);
        chk("sub35_bus_new", int'(bus), 14);
        cyc(4'd7, 4'd7, 2'b01, 1'b1, 1'b1, 1'b1);
        chk_state("sub77", 0, 1, 1, 0);

        // wrap-around and flag hold
        cyc(4'd15, 4'd1, 2'b00, 1'b1, 1'b1, 1'b1);
        chk_state("add151", 0, 1, 1, 0);
        cyc(4'd2, 4'd1, 2'b00, 1'b1, 1'b0, 1'b1);
        chk_state("hold21", 3, 1, 1, 0);
        cyc(4'd0, 4'd1, 2'b01, 1'b1, 1'b1, 1'b1);
        chk_state("sub01", 15, 0, 0, 0);
        cyc(4'd8, 4'd1, 2'b01, 1'b1, 1'b1, 1'b1);
        chk_state("sub81", 7, 1, 0, 1);

        // logic ops
        cyc(4'd12, 4'd10, 2'b10, 1'b1, 1'b1, 1'b1);
        chk_state("and", 8, 0, 0, 0);
        cyc(4'd12, 4'd10, 2'b11, 1'b1, 1'b1, 1'b1);
        chk_state("or", 14, 0, 0, 0);

        // no latch: operand churn has no effect, busy drops
        for (int i = 0; i < 3; i++) begin
            cyc(4'(i + 1), 4'(7 - i), 2'(i), 1'b0, 1'b1, 1'b1);
            chk("nolatch_r", int'(result_q), 14);
            chk("nolatch_busy", int'(busy_led), 0);
        end
        cyc(4'd1, 4'd1, 2'b00, 1'b1, 1'b1, 1'b0);
        chk("relatch_busy", int'(busy_led), 1);
        cyc(4'd1, 4'd1, 2'b00, 1'b0, 1'b1, 1'b0);
        chk("relatch_busy_off", int'(busy_led), 0);
        chk("relatch_r", int'(result_q), 2);

        @(posedge clk); #1;
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_alu_flags_4bit

// File: doc/alu_flags_4bit.md
Name: alu_flags_4bit

Overview:
- Arithmetic/logic stage directly downstream of the two 4-bit operand registers (A and B).
- Consumes their q outputs, computes add, subtract, AND or OR, and captures the result plus carry, zero and overflow flags on main_clock.
- Drives the result back onto the 4-bit bus only while its output enable is asserted.
- Flag outputs feed the control logic and front-panel LEDs.

Parameters:
- WIDTH, 4, operand, result and bus width in bits.

Ports:
- main_clock  input  1  CPU clock from the clock circuit; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  operand A (A register q outputs).
- b  input  WIDTH  operand B (B register q outputs).
- op  input  2  operation select: 00 add, 01 sub (a-b), 10 and, 11 or.
- alu_latch  input  1  capture result on this edge.
- flags_en  input  1  allow flag update on a latching edge.
- out_en  input  1  drive result_q onto bus.
- bus  output  WIDTH  result_q when out_en=1, else all zeros.
- result_q  output  WIDTH  registered result, always visible (debug/LEDs).
- carry_flag  output  1  registered carry / no-borrow.
- zero_flag  output  1  registered zero.
- overflow_flag  output  1  registered signed overflow.
- busy_led  output  1  high for the one cycle after a latch (result freshly updated).

Behaviour:
- Reset (rst_n=0, asynchronous, dominates everything):
  - result_q=0; carry_flag=0; zero_flag=0; overflow_flag=0; busy_led=0.
  - bus=0 regardless of out_en. bus remains gated by out_en after reset release.
- Combinational datapath, WIDTH+1-bit internal sum:
  - add: {c,r} = a + b.
  - sub: {c,r} = a + ~b + 1. c=1 means no borrow (a>=b unsigned).
  - and: r = a & b, c=0.
  - or: r = a | b, c=0.
  - ov (add): a[MSB]==b[MSB] && r[MSB]!=a[MSB].
  - ov (sub): a[MSB]!=b[MSB] && r[MSB]!=a[MSB].
  - ov (logic ops): 0.
- Rising main_clock with alu_latch=1:
  - result_q <= r.
  - If flags_en=1: carry_flag <= c; zero_flag <= (r==0); overflow_flag <= ov.
  - If flags_en=0: all flags hold.
- alu_latch=0: result_q and all flags hold. op, a and b changes have no effect.
- busy_led: registered copy of alu_latch (high exactly one cycle after each latching edge).
- Latency: operands to result_q/bus is 1 clock. bus follows out_en combinationally, with no added delay.
- Simultaneous out_en=1 and alu_latch=1:
  - bus shows the old result_q until the edge, then the new value.
  - The same-cycle bus value is never fed back into a or b inside this block. Loops are the sequencer's responsibility.
- Wrap-around is modulo 2^WIDTH:
  - 15+1 gives result 0, carry 1, zero 1.
  - 0-1 gives result 15, carry 0.
- A halted clock (no edges) freezes all state. Asynchronous reset still clears it.

Decomposition:
- Shared package (cpu_pkg):
  - constant ALU_WIDTH=4.
  - op encodings OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11.
  - flag bit positions FLAG_C=0, FLAG_Z=1, FLAG_V=2.
- Sub-module alu_core_comb: purely combinational; a, b, op in; r, c, ov out.
- Top level holds the result and flag registers plus the bus gating.

Test Plan:
- Reset mid-operation: latch a=5,b=3 add, then pull rst_n low between edges -> result_q=0, all flags 0 and bus=0 immediately, without waiting for a clock edge.
- Add with carry: a=9, b=8, op=00, alu_latch=1, flags_en=1, out_en=1 -> after edge result_q=1, carry=1, zero=0, overflow=1, bus=1. Same stimulus with out_en=0 -> bus=0.
- Subtract borrow and zero:
  - a=3, b=5, op=01 -> result_q=14, carry=0, zero=0, overflow=0.
  - Then a=7, b=7 -> result_q=0, carry=1, zero=1.
- Flag hold: latch a=15, b=1 add with flags_en=1 (carry=1, zero=1), then a=2, b=1, flags_en=0 -> result_q=3, carry stays 1, zero stays 1.
- Logic ops and hold:
  - a=12, b=10, op=10 -> result_q=8, carry=0.
  - op=11 -> result_q=14.
  - Change a/b with alu_latch=0 over 3 edges -> result_q stays 14; busy_led pulses only after latching edges.
